// File: rtl/fact_bcd_conv_pkg.sv
// ---------------------------------------------------------------------------
// fact_bcd_conv_pkg
// Shared constants and the FSM state type for the factorial BCD converter.
//   WIDTH  : upstream factorial-stage input width
//   BIN_W  : binary factorial operand width (WIDTH*11)
//   DIGITS : number of BCD output digits
//   state_e: converter FSM states (IDLE=0, SHIFT=1, DONE=2)
// ---------------------------------------------------------------------------
package fact_bcd_conv_pkg;

  localparam int WIDTH  = 4;
  localparam int BIN_W  = WIDTH * 11;
  localparam int DIGITS = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : fact_bcd_conv_pkg

// File: rtl/fact_bcd_conv_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: adds 3 to a BCD digit that
// is 5 or more, so that the following left shift carries correctly into the
// next decimal digit.
//   digit_i : 4-bit BCD digit before correction
//   digit_o : 4-bit corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule : bcd_digit_adj

// File: rtl/fact_bcd_conv.sv
// ---------------------------------------------------------------------------
// fact_bcd_conv
// Sequential binary-to-BCD converter (double-dabble) for factorial values.
// One operand is accepted in IDLE, converted over BIN_W SHIFT cycles, and the
// result is held in DONE until the consumer takes it.
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : upstream operand valid
//   in_ready  : converter can accept an operand (IDLE only)
//   facto     : binary factorial operand, BIN_W bits
//   out_valid : bcd/ndigits hold a completed result (DONE only)
//   out_ready : downstream accepts the result
//   bcd       : packed BCD result, digit 0 (units) in bits [3:0]
//   ndigits   : number of significant decimal digits (1..DIGITS)
//   busy      : high while converting (SHIFT)
// ---------------------------------------------------------------------------
module fact_bcd_conv
  import fact_bcd_conv_pkg::*;
#(
  parameter int WIDTH  = fact_bcd_conv_pkg::WIDTH,
  parameter int BIN_W  = WIDTH * 11,
  parameter int DIGITS = fact_bcd_conv_pkg::DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      facto,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [3:0]            ndigits,
  output logic                  busy
);

  localparam int DW    = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_e            state_q,   state_d;
  logic [BIN_W-1:0]  bin_q,     bin_d;
  logic [DW-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [DW-1:0]     bcd_q,     bcd_d;
  logic [3:0]        ndig_q,    ndig_d;

  // Per-digit add-3 correction of the current scratch.
  logic [DW-1:0]       scratch_adj;
  // Corrected scratch and binary register shifted left together by one bit.
  logic [DW+BIN_W-1:0] shifted;
  logic [DW-1:0]       scratch_shift;
  logic [3:0]          ndig_shift;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[gi*4 +: 4]),
      .digit_o (scratch_adj[gi*4 +: 4])
    );
  end

  assign shifted       = {scratch_adj, bin_q} << 1;
  assign scratch_shift = shifted[DW+BIN_W-1:BIN_W];

  // Highest nonzero digit index plus one; zero still reports one digit.
  always_comb begin
    ndig_shift = 4'd1;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_shift[k*4 +: 4] != 4'd0) begin
        ndig_shift = 4'(k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ndig_q    <= 4'd1;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ndig_q    <= ndig_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ndig_d    = ndig_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d     = facto;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy      = 1'b1;
        bin_d     = shifted[BIN_W-1:0];
        scratch_d = scratch_shift;
        cnt_d     = cnt_q + 1'b1;
        // The last shift's result goes straight into the output registers
        // so the result is visible on the first DONE cycle.
        if (cnt_q == LAST_ITER) begin
          bcd_d   = scratch_shift;
          ndig_d  = ndig_shift;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bcd     = bcd_q;
  assign ndigits = ndig_q;

endmodule : fact_bcd_conv

// File: tb/tb_fact_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_fact_bcd_conv
// Directed-vector bench for fact_bcd_conv: reset state, factorial
// conversions with hand-computed BCD, output hold in DONE, and abort by reset.
// ---------------------------------------------------------------------------
module tb_fact_bcd_conv;

  localparam int BIN_W  = 44;
  localparam int DIGITS = 14;
  localparam int DW     = DIGITS * 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  facto;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     bcd;
  logic [3:0]        ndigits;
  logic              busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fact_bcd_conv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .facto     (facto),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .ndigits   (ndigits),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Presents one operand in IDLE and waits for out_valid; leaves DUT in DONE.
  task automatic run_to_done(input string name, input logic [BIN_W-1:0] val,
                             input logic [DW-1:0] exp_bcd, input logic [3:0] exp_nd);
    int  edges;
    bit  seen;
    @(negedge clk);
    facto    = val;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, " busy_after_accept"}, 64'(busy), 64'd1);
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) seen = 1'b1;
    end
    // Cycles from the accept cycle (counted as cycle 1) to the first
    // out_valid cycle: accept + BIN_W shift cycles = BIN_W+1.
    chk({name, " latency"}, 64'(edges), 64'(BIN_W + 1));
    chk({name, " bcd"}, 64'(bcd), 64'(exp_bcd));
    chk({name, " ndigits"}, 64'(ndigits), 64'(exp_nd));
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " in_ready_after_release"}, 64'(in_ready), 64'd1);
    chk({name, " out_valid_after_release"}, 64'(out_valid), 64'd0);
  endtask

  logic [BIN_W-1:0] vec_in  [8] = '{44'd720, 44'd5040, 44'd39916800, 44'd6227020800,
                                    44'd1307674368000, 44'hFFFFFFFFFFF, 44'd1, 44'd0};
  logic [DW-1:0]    vec_bcd [8] = '{56'h720, 56'h5040, 56'h39916800, 56'h6227020800,
                                    56'h1307674368000, 56'h17592186044415, 56'h1, 56'h0};
  logic [3:0]       vec_nd  [8] = '{4'd3, 4'd4, 4'd8, 4'd10, 4'd13, 4'd14, 4'd1, 4'd1};
  string            vec_nm  [8] = '{"6!", "7!", "11!", "13!", "15!", "all_ones", "0!", "zero"};

  initial begin
    bit ov_seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    facto     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset bcd", 64'(bcd), 64'd0);
    chk("reset ndigits", 64'(ndigits), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_to_done(vec_nm[v], vec_in[v], vec_bcd[v], vec_nd[v]);
      release_result(vec_nm[v]);
      chk({vec_nm[v], " bcd_kept_in_idle"}, 64'(bcd), 64'(vec_bcd[v]));
    end

    // Hold in DONE with in_valid asserted: result frozen, nothing accepted.
    run_to_done("hold 7!", 44'd5040, 56'h5040, 4'd4);
    @(negedge clk);
    in_valid = 1'b1;
    facto    = 44'd720;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold c%0d bcd", c), 64'(bcd), 64'h5040);
      chk($sformatf("hold c%0d in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("hold c%0d out_valid", c), 64'(out_valid), 64'd1);
    end
    // Release while in_valid is still high: must not be accepted on that edge.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("hold release in_ready", 64'(in_ready), 64'd1);
    chk("hold release busy", 64'(busy), 64'd0);
    chk("hold release out_valid", 64'(out_valid), 64'd0);
    chk("hold release bcd", 64'(bcd), 64'h5040);

    // Abort by reset at shift iteration 20.
    @(negedge clk);
    facto    = 44'd6227020800;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("abort busy_before_rst", 64'(busy), 64'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort bcd", 64'(bcd), 64'd0);
    chk("abort ndigits", 64'(ndigits), 64'd1);
    ov_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) ov_seen = 1'b1;
    end
    chk("abort no_out_valid_or_busy", 64'(ov_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_fact_bcd_conv
